decode_pipe: RTL and testbench
==============================

# decode_pipe

Parametrised, handshaked successor to the single-register decode stage, sitting between fetch (`if_id_*`) and operand fetch (`id_of_*`). It splits instructions into opcode, addressing mode, register indices, sign-extended immediate and branch condition. It flags writeback per opcode via a mask, and applies valid/ready back-pressure through a one-entry skid buffer. It inserts a one-cycle bubble on load-use hazards and supports a synchronous pipeline flush.

## Interface
- `OP_W`, 5: opcode width; instruction bits [INSTR_W-1 -: OP_W].
- `REG_W`, 5: register index width.
- `INSTR_W`, 16: must equal OP_W+1+2*REG_W.
- `PC_W`, 16: program counter width.
- `DATA_W`, 16: immediate output width (≥ REG_W).
- `COND_W`, 4: branch condition width (≤ REG_W), taken from instruction LSBs.
- `WB_MASK`, 2^OP_W bits, bit 24 set: opcode n has writeback when WB_MASK[n]=1.
- `LOAD_OP`, 5'b10000: opcode treated as load for hazard detection.
- `CNT_W`, 16: stall counter width.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: discard all held/accepted instructions this cycle.
- `if_id_valid` in 1: fetch presents an instruction.
- `if_id_pc` in PC_W: PC of presented instruction.
- `if_id_instr` in INSTR_W: presented instruction.
- `id_if_ready` out 1: decode can accept; registered, equals ~skid_valid.
- `id_of_valid` out 1: decoded outputs valid.
- `of_id_ready` in 1: operand fetch accepts.
- `id_of_op` out OP_W; `id_of_addr_mode` out 1 (0 direct, 1 immediate).
- `id_of_reg_idx_a` / `id_of_reg_idx_b` out REG_W each.
- `id_of_imm` out DATA_W: operand-B field sign-extended.
- `id_of_branch_cond` out COND_W; `id_of_pc` out PC_W.
- `id_of_has_writeback` out 1; `id_of_is_load` out 1.
- `id_stall_cnt` out CNT_W: saturating count of hazard bubbles.

## Operation
- Storage: output register O (all `id_of_*` fields + valid), skid register S (pc, instr, valid), last-load record L (valid, dst = reg A index).
- Accept = `if_id_valid & id_if_ready`. Advance adv = `~O.valid | of_id_ready`.
- Candidate = S if S.valid, else accepted input.
- Hazard = candidate valid & L.valid & (cand.regA == L.dst | (cand.addr_mode==0 & cand.regB == L.dst)).
- Per cycle, adv & ~hazard: candidate decoded into O, O.valid=1. If candidate was S, S.valid←0.
- adv & hazard: O.valid←0 (bubble), L.valid←0, `id_stall_cnt`+1 saturating at all-ones. Candidate retained; an input candidate moves to S.
- ~adv: O holds all fields unchanged. An accepted input goes to S.
- L update on load into O: L.valid←(op==LOAD_OP), L.dst←regA. Cleared on bubble; unchanged when ~adv.
- Decode: op=instr[INSTR_W-1 -: OP_W]; addr_mode=next bit; regA=next REG_W; regB=imm source=low REG_W; branch_cond=low COND_W; has_writeback=WB_MASK[op]; is_load=(op==LOAD_OP).
- Flush: O.valid, S.valid, L.valid←0. The input accepted the same cycle is dropped. Counter is kept. Field registers may keep stale values.
- Reset (priority over flush): all valids 0, all `id_of_*` fields 0, counter 0, `id_if_ready`=1 the following cycle.

## Timing
- Latency: input accepted at edge k appears on `id_of_*` after edge k (one cycle) if no stall or hazard.
- Throughput 1 instr/cycle sustained while `of_id_ready`=1 and no hazards.
- `id_if_ready` falls the cycle after S captures and rises the cycle after S drains. No combinational path from `of_id_ready` to `id_if_ready`.
- Load-use costs exactly one bubble cycle. No bubble when the dependent instruction arrives ≥1 cycle after the load leaves O.
- Outputs stable while `id_of_valid & ~of_id_ready`.
- Simultaneous flush + accept + hazard: flush wins, nothing retained.

## Test plan
- Reset mid-stream with S full -> next cycle `id_of_valid`=0, `id_if_ready`=1, all fields 0, `id_stall_cnt`=0.
- Stream 0xC000, 0x0421, 0x8BE5 with `of_id_ready`=1 -> one per cycle, 1-cycle latency. 0xC000 gives op=24 and has_writeback=1. 0x8BE5 gives addr_mode=0, regA=31, regB=5.
- Immediate 0x0C3F (mode 1, B=31) -> `id_of_imm`=0xFFFF. B=0x0F -> 0x000F.
- Hold `of_id_ready`=0 for 3 cycles over a stream -> O stable, S holds one, `id_if_ready` low from the 2nd cycle, no loss or duplication on release.
- Load to r3 followed by instruction reading r3 (direct B) -> one bubble, `id_stall_cnt`=1. Same with an unrelated register -> no bubble.
- Assert `flush` while O and S are full and an input is offered -> next cycle `id_of_valid`=0, S empty, offered instruction never appears.

Source files
------------

// File: rtl/decode_pipe.sv
// Handshaked instruction decode stage: splits fetch words into operand-fetch fields,
// with a one-entry skid buffer, one-bubble load-use interlock and synchronous flush.
module decode_pipe #(
  parameter int                    OP_W    = 5,
  parameter int                    REG_W   = 5,
  parameter int                    INSTR_W = 16,
  parameter int                    PC_W    = 16,
  parameter int                    DATA_W  = 16,
  parameter int                    COND_W  = 4,
  parameter logic [(1<<OP_W)-1:0]  WB_MASK = 32'h0100_0000,
  parameter logic [OP_W-1:0]       LOAD_OP = 5'b10000,
  parameter int                    CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               if_id_valid,
  input  logic [PC_W-1:0]    if_id_pc,
  input  logic [INSTR_W-1:0] if_id_instr,
  output logic               id_if_ready,
  output logic               id_of_valid,
  input  logic               of_id_ready,
  output logic [OP_W-1:0]    id_of_op,
  output logic               id_of_addr_mode,
  output logic [REG_W-1:0]   id_of_reg_idx_a,
  output logic [REG_W-1:0]   id_of_reg_idx_b,
  output logic [DATA_W-1:0]  id_of_imm,
  output logic [COND_W-1:0]  id_of_branch_cond,
  output logic [PC_W-1:0]    id_of_pc,
  output logic               id_of_has_writeback,
  output logic               id_of_is_load,
  output logic [CNT_W-1:0]   id_stall_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [OP_W-1:0]   op;
    logic              mode;
    logic [REG_W-1:0]  ra;
    logic [REG_W-1:0]  rb;
    logic [DATA_W-1:0] imm;
    logic [COND_W-1:0] cond;
    logic              wb;
    logic              ld;
  } dec_t;

  dec_t               o, cand;
  logic               o_valid, s_valid, l_valid;
  logic [PC_W-1:0]    s_pc;
  logic [INSTR_W-1:0] s_instr;
  logic [REG_W-1:0]   l_dst;
  logic [CNT_W-1:0]   stall_cnt;
  logic [INSTR_W-1:0] c_instr;
  logic               accept, adv, cand_valid, hazard;

  // Ready comes straight from a flop, so back-pressure never forms a comb path upstream.
  assign id_if_ready = ~s_valid;
  assign accept      = if_id_valid & id_if_ready;
  assign adv         = ~o_valid | of_id_ready;
  assign cand_valid  = s_valid | accept;
  assign c_instr     = s_valid ? s_instr : if_id_instr;

  always_comb begin
    cand      = '0;
    cand.pc   = s_valid ? s_pc : if_id_pc;
    cand.op   = c_instr[INSTR_W-1 -: OP_W];
    cand.mode = c_instr[INSTR_W-1-OP_W];
    cand.ra   = c_instr[2*REG_W-1 -: REG_W];
    cand.rb   = c_instr[REG_W-1:0];
    cand.imm  = DATA_W'($signed(cand.rb));
    cand.cond = c_instr[COND_W-1:0];
    cand.wb   = WB_MASK[cand.op];
    cand.ld   = (cand.op == LOAD_OP);
  end

  // Operand B only counts as a register read in direct mode.
  assign hazard = cand_valid & l_valid &
                  ((cand.ra == l_dst) | (~cand.mode & (cand.rb == l_dst)));

  always_ff @(posedge clk) begin
    if (reset) begin
      o         <= '0;
      o_valid   <= 1'b0;
      s_valid   <= 1'b0;
      s_pc      <= '0;
      s_instr   <= '0;
      l_valid   <= 1'b0;
      l_dst     <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      o_valid <= 1'b0;
      s_valid <= 1'b0;
      l_valid <= 1'b0;
    end else if (adv) begin
      if (hazard) begin
        o_valid <= 1'b0;
        l_valid <= 1'b0;
        if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
        if (!s_valid) begin
          s_valid <= accept;
          s_pc    <= if_id_pc;
          s_instr <= if_id_instr;
        end
      end else begin
        o_valid <= cand_valid;
        l_valid <= cand_valid & cand.ld;
        s_valid <= 1'b0;
        if (cand_valid) begin
          o     <= cand;
          l_dst <= cand.ra;
        end
      end
    end else if (accept) begin
      s_valid <= 1'b1;
      s_pc    <= if_id_pc;
      s_instr <= if_id_instr;
    end
  end

  assign id_of_valid         = o_valid;
  assign id_of_op            = o.op;
  assign id_of_addr_mode     = o.mode;
  assign id_of_reg_idx_a     = o.ra;
  assign id_of_reg_idx_b     = o.rb;
  assign id_of_imm           = o.imm;
  assign id_of_branch_cond   = o.cond;
  assign id_of_pc            = o.pc;
  assign id_of_has_writeback = o.wb;
  assign id_of_is_load       = o.ld;
  assign id_stall_cnt        = stall_cnt;

endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: directed vectors push hand-decoded expectations,
// a negedge monitor pops and compares every transfer to operand fetch.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, if_id_valid, of_id_ready;
  logic [15:0] if_id_pc, if_id_instr;
  logic        id_if_ready, id_of_valid, id_of_addr_mode, id_of_has_writeback, id_of_is_load;
  logic [4:0]  id_of_op, id_of_reg_idx_a, id_of_reg_idx_b;
  logic [15:0] id_of_imm, id_of_pc, id_stall_cnt;
  logic [3:0]  id_of_branch_cond;

  typedef struct packed {
    logic [15:0] pc;
    logic [4:0]  op;
    logic        mode;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [15:0] imm;
    logic [3:0]  cond;
    logic        wb;
    logic        ld;
  } exp_t;

  exp_t q[$];
  int   tests = 0, fails = 0, npop = 0;

  decode_pipe dut (
    .clk(clk), .reset(reset), .flush(flush),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .id_if_ready(id_if_ready), .id_of_valid(id_of_valid), .of_id_ready(of_id_ready),
    .id_of_op(id_of_op), .id_of_addr_mode(id_of_addr_mode),
    .id_of_reg_idx_a(id_of_reg_idx_a), .id_of_reg_idx_b(id_of_reg_idx_b),
    .id_of_imm(id_of_imm), .id_of_branch_cond(id_of_branch_cond), .id_of_pc(id_of_pc),
    .id_of_has_writeback(id_of_has_writeback), .id_of_is_load(id_of_is_load),
    .id_stall_cnt(id_stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t cur();
    return '{id_of_pc, id_of_op, id_of_addr_mode, id_of_reg_idx_a, id_of_reg_idx_b,
             id_of_imm, id_of_branch_cond, id_of_has_writeback, id_of_is_load};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && id_of_valid && of_id_ready) begin
      npop++;
      if (q.size() == 0) chk("unexpected_output", 64'(cur()), 64'hDEAD);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("decode", 64'(cur()), 64'(e));
      end
    end
  end

  task automatic wait_accept(input string name);
    logic ok;
    int   n;
    n = 0;
    do begin
      @(negedge clk);
      ok = id_if_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 20);
    if (!ok) chk({name, "_accept_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic send(input logic [15:0] pc, input logic [15:0] instr, input exp_t e);
    q.push_back(e);
    if_id_valid = 1'b1;
    if_id_pc    = pc;
    if_id_instr = instr;
    wait_accept("send");
  endtask

  task automatic idle();
    if_id_valid = 1'b0;
  endtask

  // Hand-decoded vectors: {pc, op, mode, ra, rb, imm, cond, wb, ld}
  localparam exp_t E_C000 = '{16'h0010, 5'd24, 1'b0, 5'd0,  5'd0,  16'h0000, 4'h0, 1'b1, 1'b0};
  localparam exp_t E_0421 = '{16'h0012, 5'd0,  1'b1, 5'd1,  5'd1,  16'h0001, 4'h1, 1'b0, 1'b0};
  localparam exp_t E_8BE5 = '{16'h0014, 5'd17, 1'b0, 5'd31, 5'd5,  16'h0005, 4'h5, 1'b0, 1'b0};
  localparam exp_t E_0C3F = '{16'h0020, 5'd1,  1'b1, 5'd1,  5'd31, 16'hFFFF, 4'hF, 1'b0, 1'b0};
  localparam exp_t E_0C2F = '{16'h0022, 5'd1,  1'b1, 5'd1,  5'd15, 16'h000F, 4'hF, 1'b0, 1'b0};
  localparam exp_t E_LD_A = '{16'h0100, 5'd16, 1'b1, 5'd3,  5'd0,  16'h0000, 4'h0, 1'b0, 1'b1};
  localparam exp_t E_1023 = '{16'h0102, 5'd2,  1'b0, 5'd1,  5'd3,  16'h0003, 4'h3, 1'b0, 1'b0};
  localparam exp_t E_LD_B = '{16'h0104, 5'd16, 1'b1, 5'd3,  5'd0,  16'h0000, 4'h0, 1'b0, 1'b1};
  localparam exp_t E_1044 = '{16'h0106, 5'd2,  1'b0, 5'd2,  5'd4,  16'h0004, 4'h4, 1'b0, 1'b0};

  initial begin
    int base;
    reset = 1'b1; flush = 1'b0; if_id_valid = 1'b0; of_id_ready = 1'b0;
    if_id_pc = '0; if_id_instr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_valid", 64'(id_of_valid), 64'(0));
    chk("reset_ready", 64'(id_if_ready), 64'(1));
    chk("reset_fields", 64'(cur()), 64'(0));
    chk("reset_cnt", 64'(id_stall_cnt), 64'(0));
    @(posedge clk); #1;

    // Back-to-back stream, one per cycle with single-cycle latency
    of_id_ready = 1'b1;
    base = npop;
    send(16'h0010, 16'hC000, E_C000);
    send(16'h0012, 16'h0421, E_0421);
    send(16'h0014, 16'h8BE5, E_8BE5);
    idle();
    @(negedge clk); #1;
    chk("stream_throughput", 64'(npop - base), 64'(3));
    @(posedge clk); #1;

    // Immediate sign extension
    send(16'h0020, 16'h0C3F, E_0C3F);
    send(16'h0022, 16'h0C2F, E_0C2F);
    idle();
    repeat (2) @(posedge clk); #1;

    // Back-pressure: O holds A, S holds B, C waits
    of_id_ready = 1'b0;
    send(16'h0010, 16'hC000, E_C000);
    send(16'h0012, 16'h0421, E_0421);
    q.push_back(E_8BE5);
    if_id_pc = 16'h0014; if_id_instr = 16'h8BE5;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_ready_low", 64'(id_if_ready), 64'(0));
      chk("bp_o_stable", 64'(cur()), 64'(E_C000));
      @(posedge clk); #1;
    end
    of_id_ready = 1'b1;
    wait_accept("bp_release");
    idle();
    repeat (2) @(posedge clk); #1;
    chk("bp_drained", 64'(q.size()), 64'(0));

    // Load-use through direct operand B: one bubble
    send(16'h0100, 16'h8460, E_LD_A);
    send(16'h0102, 16'h1023, E_1023);
    idle();
    @(negedge clk);
    chk("hazard_bubble", 64'(id_of_valid), 64'(0));
    chk("hazard_cnt", 64'(id_stall_cnt), 64'(1));
    repeat (2) @(posedge clk); #1;

    // Load then unrelated register: no bubble
    send(16'h0104, 16'h8460, E_LD_B);
    send(16'h0106, 16'h1044, E_1044);
    idle();
    @(negedge clk);
    chk("nohaz_valid", 64'(id_of_valid), 64'(1));
    chk("nohaz_cnt", 64'(id_stall_cnt), 64'(1));
    repeat (2) @(posedge clk); #1;

    // Flush with O and S full while another instruction is offered
    of_id_ready = 1'b0;
    send(16'h0010, 16'hC000, E_C000);
    send(16'h0012, 16'h0421, E_0421);
    if_id_pc = 16'h0200; if_id_instr = 16'h8BE5; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; idle(); q.delete();
    @(negedge clk);
    chk("flush_valid", 64'(id_of_valid), 64'(0));
    chk("flush_s_empty", 64'(id_if_ready), 64'(1));
    chk("flush_cnt_kept", 64'(id_stall_cnt), 64'(1));
    @(posedge clk); #1;

    // Flush while an input is actually accepted: it must vanish
    send(16'h0020, 16'h0C3F, E_0C3F);
    if_id_valid = 1'b1; if_id_pc = 16'h0300; if_id_instr = 16'h0421; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; idle(); q.delete();
    @(negedge clk);
    chk("flush_acc_valid", 64'(id_of_valid), 64'(0));
    @(posedge clk); #1;
    of_id_ready = 1'b1;
    send(16'h0022, 16'h0C2F, E_0C2F);
    idle();
    repeat (2) @(posedge clk); #1;
    chk("flush_after_drained", 64'(q.size()), 64'(0));

    // Reset mid-stream with S full
    of_id_ready = 1'b0;
    send(16'h0010, 16'hC000, E_C000);
    send(16'h0012, 16'h0421, E_0421);
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; q.delete();
    @(negedge clk);
    chk("rst_mid_valid", 64'(id_of_valid), 64'(0));
    chk("rst_mid_ready", 64'(id_if_ready), 64'(1));
    chk("rst_mid_fields", 64'(cur()), 64'(0));
    chk("rst_mid_cnt", 64'(id_stall_cnt), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
